ps_cmd_seq: RTL

PS_CMD_SEQ -- requirements
Module: ps_cmd_seq

---
 rtl/psctl_pkg.sv | 27 ++
 rtl/ps_timeout_cnt.sv | 28 ++
 rtl/ps_cmd_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/psctl_pkg.sv
// Shared types and defaults for the phase-shift command sequencer.
package psctl_pkg;

  localparam int unsigned STEP_W       = 16;
  localparam int unsigned TO_W         = 24;
  localparam int unsigned HOLD_W       = 8;
  localparam int unsigned CMD_HOLD_DEF = 4;
  localparam logic [TO_W-1:0] TIMEOUT_DEF = 24'd1_000_000;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_ASSERT = 5'b00010,
    ST_RUN    = 5'b00100,
    ST_DONE   = 5'b01000,
    ST_ERR    = 5'b10000
  } state_t;

  typedef struct packed {
    logic              mode;
    logic [STEP_W-1:0] step;
  } cfg_t;

  function automatic logic [STEP_W-1:0] sat_inc(input logic [STEP_W-1:0] v);
    return (v == '1) ? v : v + STEP_W'(1);
  endfunction

endpackage

// File: rtl/ps_timeout_cnt.sv
// RUN-state watchdog: counts enabled cycles and flags the TIMEOUT-1 terminal count.
module ps_timeout_cnt
  import psctl_pkg::*;
#(
  parameter logic [TO_W-1:0] TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc_c
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  assign tc_c = en && (cnt == TIMEOUT - TO_W'(1));

endmodule

// File: rtl/ps_cmd_seq.sv
// Issues one phase-shift command, supervises the controller handshake and reports status.
module ps_cmd_seq
  import psctl_pkg::*;
#(
  parameter int unsigned     CMD_HOLD = CMD_HOLD_DEF,
  parameter logic [TO_W-1:0] TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              psclk,
  input  logic              reset_n,
  input  logic              cfg_wr,
  input  logic              cfg_mode,
  input  logic [STEP_W-1:0] cfg_step,
  input  logic              err_clr,
  output logic              pscmd,
  output logic              psmode,
  output logic [STEP_W-1:0] psstep,
  input  logic              psdone,
  input  logic              psscan_flag,
  output logic              busy,
  output logic              done_pulse,
  output logic [STEP_W-1:0] last_steps,
  output logic              err_noack,
  output logic              err_timeout,
  output logic              err_busy_wr
);

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [STEP_W-1:0] step_cnt, step_nxt;
  logic              hold_last, run_en, tc;
  logic              accept;
  cfg_t              cfg_in;

  assign cfg_in    = '{mode: cfg_mode, step: cfg_step};
  assign accept    = (state == ST_IDLE) && cfg_wr;
  assign hold_last = (state == ST_ASSERT) && (hold_cnt == HOLD_W'(CMD_HOLD - 1));
  assign run_en    = (state == ST_RUN);

  ps_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk   (psclk),
    .rst_n (reset_n),
    .en    (run_en),
    .clr   (!run_en),
    .tc_c  (tc)
  );

  // Next state and next step count; falling psscan_flag beats the timeout.
  always_comb begin
    state_nxt = state;
    step_nxt  = step_cnt;
    unique case (state)
      ST_IDLE:   if (cfg_wr) state_nxt = ST_ASSERT;
      ST_ASSERT: if (hold_last) state_nxt = psscan_flag ? ST_RUN : ST_ERR;
      ST_RUN: begin
        if (!psscan_flag) state_nxt = ST_DONE;
        else if (tc)      state_nxt = ST_ERR;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      ST_ERR:    if (err_clr) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (accept) begin
      step_nxt = '0;
    end else if (psdone && ((state == ST_ASSERT) || (state == ST_RUN))) begin
      step_nxt = sat_inc(step_cnt);
    end
  end

  // State, counters and registered outputs (outputs decoded from the next state).
  always_ff @(posedge psclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      step_cnt    <= '0;
      pscmd       <= 1'b0;
      psmode      <= 1'b0;
      psstep      <= '0;
      busy        <= 1'b0;
      done_pulse  <= 1'b0;
      last_steps  <= '0;
      err_noack   <= 1'b0;
      err_timeout <= 1'b0;
      err_busy_wr <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_cnt   <= step_nxt;
      hold_cnt   <= (state == ST_ASSERT) ? hold_cnt + HOLD_W'(1) : '0;
      pscmd      <= (state_nxt == ST_ASSERT);
      busy       <= (state_nxt != ST_IDLE);
      done_pulse <= (state_nxt == ST_DONE);
      if (accept) begin
        psmode <= cfg_in.mode;
        psstep <= cfg_in.step;
      end
      if (state_nxt == ST_DONE) last_steps <= step_nxt;
      if (err_clr) begin
        err_noack   <= 1'b0;
        err_timeout <= 1'b0;
        err_busy_wr <= 1'b0;
      end else begin
        if (hold_last && !psscan_flag)               err_noack   <= 1'b1;
        if (run_en && psscan_flag && tc)             err_timeout <= 1'b1;
        if (cfg_wr && (state != ST_IDLE))            err_busy_wr <= 1'b1;
      end
    end
  end

endmodule
